// File: rtl/hram_port_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of the HyperRAM controller's s0 port.
// Each command goes out as a single-cycle strobe, followed by an enforced idle gap; lost reads time out.
module hram_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RD_TIMEOUT    = 1023,
  parameter int GAP_CYCLES    = 2,
  parameter int WR_GAP_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  input  logic              s_waitrequest,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int TMAX_A = (RD_TIMEOUT > WR_GAP_CYCLES) ? RD_TIMEOUT : WR_GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > GAP_CYCLES) ? TMAX_A : GAP_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0]     TO_LAST  = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0]     RD_GAP   = TW'(GAP_CYCLES);
  localparam logic [TW-1:0]     WR_GAP   = TW'(WR_GAP_CYCLES);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, GAP} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_read_q, cmd_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic              req0, req1, pick;
  logic [DATA_W-1:0] resp_data;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  // On a tie the master that was not served last wins.
  assign pick      = (req0 && req1) ? ~last_grant_q : ~req0;
  assign resp_data = s_readdatavalid ? s_readdata : ERR_DATA;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_read_d   = cmd_read_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    timer_d      = timer_q;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d    = pick;
          cmd_read_d = pick ? m1_read : m0_read;
          addr_d     = pick ? m1_address : m0_address;
          wdata_d    = pick ? m1_writedata : m0_writedata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_waitrequest) begin
          if (cmd_read_q) begin
            timer_d = '0;
            state_d = RD_WAIT;
          end else begin
            timer_d = WR_GAP;
            state_d = GAP;
          end
        end
      end
      RD_WAIT: begin
        // Real data beats a timeout landing in the same cycle.
        if (s_readdatavalid || timer_q == TO_LAST) begin
          if (grant_q) begin
            rdata1_d  = resp_data;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = resp_data;
            rvalid0_d = 1'b1;
          end
          if (!s_readdatavalid && err_q != 8'hFF) err_d = err_q + 8'd1;
          timer_d = RD_GAP;
          state_d = GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (timer_q <= TW'(1)) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_read_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      timer_q      <= '0;
      err_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_read_q   <= cmd_read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign s_address        = addr_q;
  assign s_writedata      = wdata_q;
  assign s_read           = (state_q == ISSUE) &&  cmd_read_q;
  assign s_write          = (state_q == ISSUE) && !cmd_read_q;
  assign m0_waitrequest   = !((state_q == ISSUE) && !grant_q && !s_waitrequest);
  assign m1_waitrequest   = !((state_q == ISSUE) &&  grant_q && !s_waitrequest);
  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
  assign m0_readdatavalid = rvalid0_q;
  assign m1_readdatavalid = rvalid1_q;
  assign busy             = (state_q != IDLE);
  assign err_count        = err_q;

endmodule
